// File: rtl/burst_sched_if.sv
// Signal bundle between the real-time command register and the burst scheduler:
// command fields in, DDS / T-R switching controls and status out.
interface burst_sched_if #(parameter int NW = 16);
    logic [63:0]   TIME;
    logic          ABORT;
    logic          CMD_VALID;
    logic [63:0]   CMD_TIME_START;
    logic [NW-1:0] CMD_N_impuls;
    logic [1:0]    CMD_TYPE;
    logic [31:0]   CMD_Ti, CMD_Tp, CMD_Tblank1, CMD_Tblank2;
    logic          REQ_COMMAND, DDS_START, En_Iz, En_Pr, BUSY, LATE, CMD_OVR;
    logic [NW-1:0] PULSE_IDX;

    modport master (
        output TIME, ABORT, CMD_VALID, CMD_TIME_START, CMD_N_impuls, CMD_TYPE,
               CMD_Ti, CMD_Tp, CMD_Tblank1, CMD_Tblank2,
        input  REQ_COMMAND, DDS_START, En_Iz, En_Pr, BUSY, PULSE_IDX, LATE, CMD_OVR
    );
    modport slave (
        input  TIME, ABORT, CMD_VALID, CMD_TIME_START, CMD_N_impuls, CMD_TYPE,
               CMD_Ti, CMD_Tp, CMD_Tblank1, CMD_Tblank2,
        output REQ_COMMAND, DDS_START, En_Iz, En_Pr, BUSY, PULSE_IDX, LATE, CMD_OVR
    );
endinterface

// File: rtl/burst_sched.sv
// Runs one latched command as N impulses of Tblank1 -> emission -> Tblank2 -> reception,
// starting at an absolute system time; phase lengths are in TICK_DIV-cycle ticks.
module burst_sched #(
    parameter int TICK_DIV = 48,
    parameter int NW       = 16
) (
    input logic          CLK,
    input logic          RESET,
    burst_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARMED, BLANK1, IZ, BLANK2, PR, DONE} stateT;
    localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);

    stateT         state, stateNext, firstPh, afterCur;
    logic [63:0]   tStart;
    logic [NW-1:0] nImp, idx, idxNext;
    logic          coherent, started, latch, impStart, phaseEnd;
    logic [31:0]   lenB1, lenIz, lenB2, lenPr, curLen;
    logic [7:0]    presc, prescNext;
    logic [31:0]   tick, tickNext;
    logic [3:0]    nz;
    logic          reqNext, ddsNext, lateNext, ovrNext;
    logic          reqQ, ddsQ, izQ, prQ, busyQ, lateQ, ovrQ;

    // Next non-empty phase after cur within one impulse; ARMED means the impulse is over.
    function automatic stateT phaseAfter(input stateT cur, input logic [3:0] nzMask);
        phaseAfter = ARMED;
        if (cur == ARMED && nzMask[0])                       phaseAfter = BLANK1;
        else if ((cur == ARMED || cur == BLANK1) && nzMask[1]) phaseAfter = IZ;
        else if (cur != PR && cur != BLANK2 && nzMask[2])     phaseAfter = BLANK2;
        else if (cur != PR && nzMask[3])                      phaseAfter = PR;
    endfunction

    assign nz       = {lenPr != 32'd0, lenB2 != 32'd0, lenIz != 32'd0, lenB1 != 32'd0};
    assign afterCur = phaseAfter(state, nz);
    // An all-zero impulse still spends one cycle in BLANK1 so its DDS strobe goes out.
    assign firstPh  = (nz == 4'b0000) ? BLANK1 : phaseAfter(ARMED, nz);

    always_comb begin
        curLen = '0;
        case (state)
            BLANK1:  curLen = lenB1;
            IZ:      curLen = lenIz;
            BLANK2:  curLen = lenB2;
            PR:      curLen = lenPr;
            default: curLen = '0;
        endcase
    end

    assign phaseEnd = (curLen == 32'd0) || (presc == PRESC_MAX && tick == curLen - 32'd1);

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        prescNext = (presc == PRESC_MAX) ? 8'd0 : presc + 8'd1;
        tickNext  = (presc == PRESC_MAX) ? tick + 32'd1 : tick;
        reqNext   = !started;
        ddsNext   = 1'b0;
        lateNext  = 1'b0;
        ovrNext   = 1'b0;
        latch     = 1'b0;
        impStart  = 1'b0;
        case (state)
            IDLE: if (bus.CMD_VALID && !bus.ABORT) begin
                latch = 1'b1;
                if (bus.TIME > bus.CMD_TIME_START) begin
                    lateNext = 1'b1;
                    reqNext  = 1'b1;
                end else begin
                    idxNext   = '0;
                    stateNext = (bus.CMD_N_impuls == '0) ? DONE : ARMED;
                end
            end
            ARMED: if (bus.TIME >= tStart) impStart = 1'b1;
            DONE: begin
                stateNext = IDLE;
                reqNext   = 1'b1;
            end
            default: if (phaseEnd) begin
                if (afterCur != ARMED) begin
                    stateNext = afterCur;
                    prescNext = '0;
                    tickNext  = '0;
                end else if (idx == nImp - NW'(1)) begin
                    stateNext = DONE;
                end else begin
                    idxNext  = idx + NW'(1);
                    impStart = 1'b1;
                end
            end
        endcase
        if (impStart) begin
            stateNext = firstPh;
            prescNext = '0;
            tickNext  = '0;
            ddsNext   = !coherent || idxNext == '0;
        end
        if (state != IDLE && bus.ABORT) begin
            stateNext = IDLE;
            reqNext   = 1'b1;
            ddsNext   = 1'b0;
        end
        if (state != IDLE && bus.CMD_VALID && !bus.ABORT) ovrNext = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            presc    <= '0;
            tick     <= '0;
            idx      <= '0;
            started  <= 1'b0;
            tStart   <= '0;
            nImp     <= '0;
            coherent <= 1'b0;
            lenB1    <= '0;
            lenIz    <= '0;
            lenB2    <= '0;
            lenPr    <= '0;
            reqQ     <= 1'b0;
            ddsQ     <= 1'b0;
            izQ      <= 1'b0;
            prQ      <= 1'b0;
            busyQ    <= 1'b0;
            lateQ    <= 1'b0;
            ovrQ     <= 1'b0;
        end else begin
            state   <= stateNext;
            presc   <= prescNext;
            tick    <= tickNext;
            idx     <= idxNext;
            started <= 1'b1;
            reqQ    <= reqNext;
            ddsQ    <= ddsNext;
            izQ     <= stateNext == IZ;
            prQ     <= stateNext == PR;
            busyQ   <= stateNext != IDLE;
            lateQ   <= lateNext;
            ovrQ    <= ovrNext;
            if (latch) begin
                tStart   <= bus.CMD_TIME_START;
                nImp     <= bus.CMD_N_impuls;
                coherent <= bus.CMD_TYPE[0];
                lenB1    <= bus.CMD_Tblank1;
                lenIz    <= bus.CMD_Ti;
                lenB2    <= bus.CMD_Tblank2;
                lenPr    <= bus.CMD_Tp;
            end
        end
    end

    assign bus.REQ_COMMAND = reqQ;
    assign bus.DDS_START   = ddsQ;
    assign bus.En_Iz       = izQ;
    assign bus.En_Pr       = prQ;
    assign bus.BUSY        = busyQ;
    assign bus.PULSE_IDX   = idx;
    assign bus.LATE        = lateQ;
    assign bus.CMD_OVR     = ovrQ;
endmodule

// File: tb/tb_burst_sched.sv
// Bench for burst_sched: directed scenarios plus random commands, every cycle checked
// against a closed-form timeline of the impulse train.
module tb_burst_sched;
    localparam int D  = 4;
    localparam int NW = 16;

    logic clk48 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk48 = ~clk48;

    burst_sched_if #(.NW(NW)) bus();
    burst_sched #(.TICK_DIV(D), .NW(NW)) dut (.CLK(clk48), .RESET(rst), .bus(bus));

    typedef struct packed {
        logic req, dds, iz, pr, busy, late, ovr;
        logic [NW-1:0] idx;
    } outT;
    typedef struct {
        longint t0, s;
        int     n;
        bit     coh;
        int     b1, ti, b2, tp;
        int     prevIdx;
    } cmdT;

    int nChk    = 0;
    int nFail   = 0;
    int lastIdx = 0;

    function automatic cmdT mk(longint t0, longint s, int n, bit coh, int b1, int ti, int b2, int tp);
        cmdT c;
        c.t0 = t0; c.s = s; c.n = n; c.coh = coh;
        c.b1 = b1; c.ti = ti; c.b2 = b2; c.tp = tp;
        c.prevIdx = lastIdx;
        return c;
    endfunction

    function automatic void retire(cmdT c);
        if (c.t0 > c.s) return;
        lastIdx = (c.n == 0) ? 0 : c.n - 1;
    endfunction

    // Expected outputs in cycle j, where cycle 0 is the one carrying CMD_VALID.
    function automatic outT model(cmdT c, int j);
        outT e;
        longint fire, p0, sum, per, endI, k, off;
        e = '0;
        if (c.t0 > c.s) begin
            e.idx = NW'(c.prevIdx); e.late = (j == 1); e.req = (j == 1);
            return e;
        end
        if (c.n == 0) begin
            e.busy = (j == 1); e.req = (j == 2);
            return e;
        end
        fire = (c.s - c.t0 > 1) ? c.s - c.t0 : 1;
        p0   = fire + 1;
        sum  = c.b1 + c.ti + c.b2 + c.tp;
        per  = (sum == 0) ? 1 : sum * D;
        endI = p0 + c.n * per;
        if (j < p0) e.busy = 1'b1;
        else if (j < endI) begin
            k = (j - p0) / per; off = (j - p0) % per;
            e.busy = 1'b1; e.idx = NW'(k);
            e.dds  = (off == 0) && (!c.coh || k == 0);
            e.iz   = off >= c.b1 * D && off < (c.b1 + c.ti) * D;
            e.pr   = off >= (c.b1 + c.ti + c.b2) * D && off < sum * D;
        end else begin
            e.idx = NW'(c.n - 1); e.busy = (j == endI); e.req = (j == endI + 1);
        end
        return e;
    endfunction

    function automatic int lastCycle(cmdT c);
        longint fire, sum, per;
        if (c.t0 > c.s) return 1;
        if (c.n == 0) return 2;
        fire = (c.s - c.t0 > 1) ? c.s - c.t0 : 1;
        sum  = c.b1 + c.ti + c.b2 + c.tp;
        per  = (sum == 0) ? 1 : sum * D;
        return int'(fire + 1 + c.n * per + 1);
    endfunction

    function automatic outT sample();
        outT o;
        o.req = bus.REQ_COMMAND; o.dds = bus.DDS_START; o.iz = bus.En_Iz; o.pr = bus.En_Pr;
        o.busy = bus.BUSY; o.late = bus.LATE; o.ovr = bus.CMD_OVR; o.idx = bus.PULSE_IDX;
        return o;
    endfunction

    task automatic cycle();
        @(posedge clk48); #1;
        bus.TIME = bus.TIME + 64'd1;
        bus.CMD_VALID = 1'b0;
        bus.ABORT = 1'b0;
    endtask

    task automatic issue(input cmdT c);
        bus.TIME           = 64'(c.t0);
        bus.CMD_VALID      = 1'b1;
        bus.CMD_TIME_START = 64'(c.s);
        bus.CMD_N_impuls   = NW'(c.n);
        bus.CMD_TYPE       = {1'($urandom_range(0, 1)), c.coh};
        bus.CMD_Tblank1    = 32'(c.b1);
        bus.CMD_Ti         = 32'(c.ti);
        bus.CMD_Tblank2    = 32'(c.b2);
        bus.CMD_Tp         = 32'(c.tp);
    endtask

    task automatic test_reset();
        outT o, e;
        rst = 1'b1;
        repeat (3) cycle();
        o = sample(); e = '0;
        nChk++; if (o !== e) begin nFail++; $display("FAIL reset_state got %h want %h", o, e); end
        rst = 1'b0;
        cycle(); o = sample(); e.req = 1'b1;
        nChk++; if (o !== e) begin nFail++; $display("FAIL reset_req got %h want %h", o, e); end
        cycle(); o = sample(); e = '0;
        nChk++; if (o !== e) begin nFail++; $display("FAIL reset_req_once got %h want %h", o, e); end
    endtask

    task automatic test_incoherent();
        cmdT c; outT o, e;
        int ddsN = 0, izN = 0, prN = 0, firstDds = -1, reqAt = -1;
        c = mk(100, 110, 2, 1'b0, 1, 3, 1, 2);
        issue(c);
        for (int j = 1; j <= lastCycle(c); j++) begin
            cycle(); o = sample(); e = model(c, j);
            nChk++; if (o !== e) begin nFail++; $display("FAIL incoherent j=%0d got %h want %h", j, o, e); end
            if (o.dds) begin ddsN++; if (firstDds < 0) firstDds = j; end
            if (o.iz) izN++;
            if (o.pr) prN++;
            if (o.req) reqAt = j;
        end
        nChk++; if (ddsN != 2 || izN != 24 || prN != 16)
            begin nFail++; $display("FAIL incoherent_counts got dds=%0d iz=%0d pr=%0d want 2/24/16", ddsN, izN, prN); end
        nChk++; if (reqAt - firstDds != 57)
            begin nFail++; $display("FAIL incoherent_req_delay got %0d want 57", reqAt - firstDds); end
        retire(c);
    endtask

    task automatic test_coherent();
        cmdT c; outT o, e;
        int ddsN = 0, izN = 0;
        c = mk(longint'(bus.TIME), longint'(bus.TIME) + 10, 3, 1'b1, 1, 3, 1, 2);
        issue(c);
        for (int j = 1; j <= lastCycle(c); j++) begin
            cycle(); o = sample(); e = model(c, j);
            nChk++; if (o !== e) begin nFail++; $display("FAIL coherent j=%0d got %h want %h", j, o, e); end
            if (o.dds) ddsN++;
            if (o.iz) izN++;
        end
        nChk++; if (ddsN != 1 || izN != 36)
            begin nFail++; $display("FAIL coherent_counts got dds=%0d iz=%0d want 1/36", ddsN, izN); end
        retire(c);
    endtask

    task automatic test_late();
        cmdT c; outT o, e;
        c = mk(500, 400, 2, 1'b0, 1, 1, 1, 1);
        issue(c);
        cycle(); o = sample(); e = model(c, 1);
        nChk++; if (o !== e) begin nFail++; $display("FAIL late got %h want %h", o, e); end
        retire(c);
        for (int j = 0; j < 3; j++) begin
            cycle(); o = sample(); e = '0; e.idx = NW'(lastIdx);
            nChk++; if (o !== e) begin nFail++; $display("FAIL late_idle j=%0d got %h want %h", j, o, e); end
        end
        // start time equal to current time is not late
        c = mk(longint'(bus.TIME), longint'(bus.TIME), 1, 1'b0, 0, 1, 0, 0);
        issue(c);
        for (int j = 1; j <= lastCycle(c); j++) begin
            cycle(); o = sample(); e = model(c, j);
            nChk++; if (o !== e) begin nFail++; $display("FAIL start_equal j=%0d got %h want %h", j, o, e); end
        end
        retire(c);
    endtask

    task automatic test_zero();
        cmdT c; outT o, e;
        c = mk(longint'(bus.TIME), longint'(bus.TIME) + 3, 0, 1'b0, 1, 1, 1, 1);
        issue(c);
        for (int j = 1; j <= lastCycle(c) + 1; j++) begin
            cycle(); o = sample(); e = model(c, j);
            nChk++; if (o !== e) begin nFail++; $display("FAIL n_zero j=%0d got %h want %h", j, o, e); end
        end
        retire(c);
        c = mk(longint'(bus.TIME), longint'(bus.TIME) + 2, 2, 1'b0, 0, 1, 0, 1);
        issue(c);
        for (int j = 1; j <= lastCycle(c); j++) begin
            cycle(); o = sample(); e = model(c, j);
            nChk++; if (o !== e) begin nFail++; $display("FAIL zero_blank j=%0d got %h want %h", j, o, e); end
        end
        retire(c);
    endtask

    task automatic test_abort();
        cmdT c; outT o, e;
        int izSeen = 0, j = 0;
        c = mk(longint'(bus.TIME), longint'(bus.TIME) + 5, 2, 1'b0, 1, 3, 1, 2);
        issue(c);
        while (izSeen < 5 && j < 100) begin
            j++; cycle(); o = sample(); e = model(c, j);
            nChk++; if (o !== e) begin nFail++; $display("FAIL abort_run j=%0d got %h want %h", j, o, e); end
            if (e.iz) izSeen++;
        end
        bus.ABORT = 1'b1;
        cycle(); o = sample(); e = '0; e.req = 1'b1;
        nChk++; if (o !== e) begin nFail++; $display("FAIL abort got %h want %h", o, e); end
        cycle(); o = sample(); e = '0;
        nChk++; if (o !== e) begin nFail++; $display("FAIL abort_idle got %h want %h", o, e); end
        lastIdx = 0;
    endtask

    task automatic test_reset_mid();
        cmdT c; outT o, e;
        int j = 0;
        bit inPr = 1'b0;
        c = mk(longint'(bus.TIME), longint'(bus.TIME) + 4, 3, 1'b0, 1, 1, 1, 2);
        issue(c);
        while (!inPr && j < 100) begin
            j++; cycle(); o = sample(); e = model(c, j);
            nChk++; if (o !== e) begin nFail++; $display("FAIL rstmid_run j=%0d got %h want %h", j, o, e); end
            inPr = e.pr && e.idx == NW'(1);
        end
        rst = 1'b1;
        cycle(); o = sample(); e = '0;
        nChk++; if (o !== e) begin nFail++; $display("FAIL rstmid_clear got %h want %h", o, e); end
        cycle(); rst = 1'b0;
        cycle(); o = sample(); e.req = 1'b1;
        nChk++; if (o !== e) begin nFail++; $display("FAIL rstmid_req got %h want %h", o, e); end
        cycle(); o = sample(); e = '0;
        nChk++; if (o !== e) begin nFail++; $display("FAIL rstmid_idle got %h want %h", o, e); end
        lastIdx = 0;
    endtask

    task automatic test_overrun();
        cmdT c; outT o, e;
        c = mk(longint'(bus.TIME), longint'(bus.TIME) + 8, 2, 1'b0, 1, 1, 0, 1);
        issue(c);
        for (int j = 1; j <= lastCycle(c); j++) begin
            cycle(); o = sample(); e = model(c, j); e.ovr = (j == 4);
            nChk++; if (o !== e) begin nFail++; $display("FAIL overrun j=%0d got %h want %h", j, o, e); end
            if (j == 3) begin
                bus.CMD_VALID = 1'b1; bus.CMD_N_impuls = NW'(7); bus.CMD_Ti = 32'd9;
                bus.CMD_TIME_START = bus.TIME; bus.CMD_TYPE = 2'b01;
            end
        end
        retire(c);
        c = mk(longint'(bus.TIME), longint'(bus.TIME) + 20, 1, 1'b0, 1, 1, 1, 1);
        issue(c);
        for (int j = 1; j <= 3; j++) begin
            cycle(); o = sample(); e = model(c, j);
            nChk++; if (o !== e) begin nFail++; $display("FAIL abort_cmd_run j=%0d got %h want %h", j, o, e); end
        end
        bus.ABORT = 1'b1; bus.CMD_VALID = 1'b1; bus.CMD_TIME_START = bus.TIME;
        cycle(); o = sample(); e = '0; e.req = 1'b1;
        nChk++; if (o !== e) begin nFail++; $display("FAIL abort_with_cmd got %h want %h", o, e); end
        cycle(); o = sample(); e = '0;
        nChk++; if (o !== e) begin nFail++; $display("FAIL abort_with_cmd_idle got %h want %h", o, e); end
        lastIdx = 0;
    endtask

    task automatic test_back_to_back();
        cmdT c; outT o, e;
        for (int r = 0; r < 2; r++) begin
            c = (r == 0) ? mk(longint'(bus.TIME), longint'(bus.TIME) + 3, 1, 1'b0, 0, 1, 0, 1)
                         : mk(longint'(bus.TIME), longint'(bus.TIME), 3, 1'b1, 0, 0, 0, 0);
            issue(c);
            for (int j = 1; j <= lastCycle(c); j++) begin
                cycle(); o = sample(); e = model(c, j);
                nChk++; if (o !== e) begin nFail++; $display("FAIL back_to_back r=%0d j=%0d got %h want %h", r, j, o, e); end
            end
            retire(c);
        end
    endtask

    task automatic test_random();
        cmdT c; outT o, e;
        longint t0, s;
        for (int r = 0; r < 30; r++) begin
            t0 = ($urandom_range(0, 6) == 0) ? longint'($urandom_range(1000, 90000)) : longint'(bus.TIME);
            if ($urandom_range(0, 5) == 0) s = t0 - longint'($urandom_range(1, 60));
            else s = t0 + longint'($urandom_range(0, 12));
            c = mk(t0, s, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            issue(c);
            for (int j = 1; j <= lastCycle(c); j++) begin
                cycle(); o = sample(); e = model(c, j);
                nChk++; if (o !== e) begin nFail++; $display("FAIL random r=%0d j=%0d got %h want %h", r, j, o, e); end
            end
            retire(c);
            if ($urandom_range(0, 2) == 0) begin
                for (int g = 0; g < 2; g++) begin
                    cycle(); o = sample(); e = '0; e.idx = NW'(lastIdx);
                    nChk++; if (o !== e) begin nFail++; $display("FAIL random_idle r=%0d got %h want %h", r, o, e); end
                end
            end
        end
    endtask

    initial begin
        bus.TIME = '0; bus.ABORT = 1'b0; bus.CMD_VALID = 1'b0; bus.CMD_TIME_START = '0;
        bus.CMD_N_impuls = '0; bus.CMD_TYPE = '0; bus.CMD_Ti = '0; bus.CMD_Tp = '0;
        bus.CMD_Tblank1 = '0; bus.CMD_Tblank2 = '0;
        test_reset();
        test_incoherent();
        test_coherent();
        test_late();
        test_zero();
        test_abort();
        test_reset_mid();
        test_overrun();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule
